// File: rtl/carry_counter_pkg.sv
// Shared constants for the carry_counter slice: legal WIDTH range.
package carry_counter_pkg;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
endpackage

// File: rtl/carry_incrementer.sv
// Combinational WIDTH-bit incrementer built as a ripple carry chain; cin adds one.
// Zero latency, no flow control.
module carry_incrementer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ c[i];
    assign c[i+1]   = a[i] & c[i];
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/carry_counter.sv
// Free-running up-counter with enable; count is registered (1 cycle after enb),
// carryout is combinational and only high when an enabled edge wraps all-ones to 0.
module carry_counter
  import carry_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  output logic [WIDTH-1:0] count,
  output logic             carryout
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("carry_counter: WIDTH must be in 1..64");
  end

  logic [WIDTH-1:0] count_nxt;

  // enb is the carry-in, so the chain's final carry is exactly enb & all-ones.
  carry_incrementer #(
    .WIDTH (WIDTH)
  ) u_inc (
    .a    (count),
    .cin  (enb),
    .sum  (count_nxt),
    .cout (carryout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enb) begin
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_carry_counter.sv
// Randomised and directed checks of carry_counter at WIDTH 8, 4 and 1 against
// an arithmetic reference model (modulo counter plus wrap detection).
module tb_carry_counter;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] enb_v;

  logic [7:0] count8;
  logic [3:0] count4;
  logic [0:0] count1;
  logic       co8, co4, co1;

  int        n_checks;
  int        n_pass;
  longint unsigned model_cnt [3];
  int        widths [3];

  carry_counter #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst_v[0]),
    .enb      (enb_v[0]),
    .count    (count8),
    .carryout (co8)
  );

  carry_counter #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst_v[1]),
    .enb      (enb_v[1]),
    .count    (count4),
    .carryout (co4)
  );

  carry_counter #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst_v[2]),
    .enb      (enb_v[2]),
    .count    (count1),
    .carryout (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] dut_count(input int idx);
    case (idx)
      0:       return {56'd0, count8};
      1:       return {60'd0, count4};
      default: return {63'd0, count1};
    endcase
  endfunction

  function automatic logic dut_carry(input int idx);
    case (idx)
      0:       return co8;
      1:       return co4;
      default: return co1;
    endcase
  endfunction

  // One clock cycle: apply inputs, compare against the model, clock, advance the model.
  task automatic run_cycle(input logic [2:0] r, input logic [2:0] e, output logic [2:0] co);
    longint unsigned top;
    rst_v = r;
    enb_v = e;
    #1;
    for (int i = 0; i < 3; i++) begin
      top = (longint'(1) << widths[i]) - 1;
      co[i] = dut_carry(i);
      check($sformatf("count_w%0d", widths[i]), dut_count(i), model_cnt[i]);
      check($sformatf("carry_w%0d", widths[i]), {63'd0, co[i]},
            {63'd0, (e[i] && model_cnt[i] == top)});
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      top = (longint'(1) << widths[i]) - 1;
      if (r[i])      model_cnt[i] = 0;
      else if (e[i]) model_cnt[i] = (model_cnt[i] + 1) & top;
    end
    #1;
  endtask

  initial begin
    logic [2:0] co;
    int         fin_k;
    int         guard;
    logic [2:0] r, e;

    n_checks = 0;
    n_pass   = 0;
    widths[0] = 8; widths[1] = 4; widths[2] = 1;
    for (int i = 0; i < 3; i++) model_cnt[i] = 0;

    // Reset with enb high; outputs undefined until the first edge.
    rst_v = 3'b111;
    enb_v = 3'b111;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) run_cycle(3'b111, 3'b111, co);
    for (int k = 0; k < 3; k++) run_cycle(3'b000, 3'b000, co);
    check("hold_after_reset_w8", {56'd0, count8}, 64'd0);

    // Basic count: 1..5 on successive edges.
    for (int k = 1; k <= 5; k++) begin
      run_cycle(3'b000, 3'b111, co);
      check("basic_w8", {56'd0, count8}, 64'(k));
      check("basic_w1", {63'd0, count1}, 64'(k % 2));
    end

    // Scenario: after reset, the first carry on WIDTH=4 lands on enabled cycle 16.
    run_cycle(3'b111, 3'b000, co);
    fin_k = 0;
    for (int k = 1; k <= 40; k++) begin
      run_cycle(3'b000, 3'b111, co);
      if (co[1]) begin
        fin_k = k;
        break;
      end
    end
    check("finish_cycle_w4", 64'(fin_k), 64'd16);
    check("wrap_to_zero_w4", {60'd0, count4}, 64'd0);

    // Enable gating at all-ones on WIDTH=4.
    run_cycle(3'b111, 3'b000, co);
    guard = 0;
    while (model_cnt[1] != 15 && guard < 40) begin
      run_cycle(3'b000, 3'b010, co);
      guard++;
    end
    check("reach_15_w4", {60'd0, count4}, 64'd15);
    run_cycle(3'b000, 3'b000, co);
    check("gated_carry_w4", {63'd0, co[1]}, 64'd0);
    run_cycle(3'b000, 3'b000, co);
    check("gated_hold_w4", {60'd0, count4}, 64'd15);
    run_cycle(3'b000, 3'b010, co);
    check("regate_carry_w4", {63'd0, co[1]}, 64'd1);
    check("regate_wrap_w4", {60'd0, count4}, 64'd0);

    // Mid-run reset on WIDTH=8 at 0x7A with enb still high.
    run_cycle(3'b111, 3'b000, co);
    guard = 0;
    while (model_cnt[0] != 64'h7A && guard < 300) begin
      run_cycle(3'b000, 3'b001, co);
      guard++;
    end
    check("reach_7a_w8", {56'd0, count8}, 64'h7A);
    run_cycle(3'b001, 3'b001, co);
    check("midrun_rst_w8", {56'd0, count8}, 64'h00);
    run_cycle(3'b000, 3'b001, co);
    check("resume_w8", {56'd0, count8}, 64'h01);

    // Random traffic: rare resets, mostly enabled.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        r[i] = ($urandom_range(511) == 0);
        e[i] = ($urandom_range(3) != 0);
      end
      run_cycle(r, e, co);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
